// File: rtl/lcd1602_bus_reader_if.sv
// Request/result handshake plus the HD44780-style read bus of the LCD1602 reader.
interface lcd1602_bus_reader_if;
  logic       rd_req;
  logic       rd_rs;
  logic       poll_req;
  logic       rd_ready;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       busy_flag;
  logic [6:0] addr_cnt;
  logic       poll_timeout;
  logic       LCD_EN;
  logic       RS;
  logic       RW;
  logic [7:0] DB8;

  modport master (
    output rd_req, rd_rs, poll_req, DB8,
    input  rd_ready, rd_valid, rd_data, busy_flag, addr_cnt, poll_timeout,
           LCD_EN, RS, RW
  );

  modport slave (
    input  rd_req, rd_rs, poll_req, DB8,
    output rd_ready, rd_valid, rd_data, busy_flag, addr_cnt, poll_timeout,
           LCD_EN, RS, RW
  );
endinterface

// File: rtl/lcd1602_bus_reader.sv
// LCD1602 read engine: single status/data reads and busy-flag polling with
// cycle-exact setup, enable-pulse, hold and recovery phases.
module lcd1602_bus_reader #(
  parameter int unsigned TAS_CYC  = 3,
  parameter int unsigned TPW_CYC  = 25,
  parameter int unsigned TH_CYC   = 2,
  parameter int unsigned TREC_CYC = 25,
  parameter int unsigned POLL_MAX = 1000
) (
  input logic                sys_clk,
  input logic                sys_rst,
  lcd1602_bus_reader_if.slave bus
);

  localparam int unsigned MAX_A  = (TAS_CYC > TPW_CYC) ? TAS_CYC : TPW_CYC;
  localparam int unsigned MAX_B  = (TH_CYC > TREC_CYC) ? TH_CYC : TREC_CYC;
  localparam int unsigned PH_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned PH_W   = $clog2(PH_MAX + 1);
  localparam int unsigned POLL_W = $clog2(POLL_MAX + 1);

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, RECOV, DONE} state_t;

  state_t              state_q, state_d;
  logic [PH_W-1:0]     ph_q, ph_d;
  logic [POLL_W-1:0]   poll_cnt_q, poll_cnt_d;
  logic                poll_mode_q, poll_mode_d;
  logic                rs_q, rs_d;
  logic [7:0]          cap_q, cap_d;
  logic [7:0]          rd_data_q, rd_data_d;
  logic                busy_q, busy_d;
  logic [6:0]          ac_q, ac_d;
  logic                timeout_q, timeout_d;
  logic                en_q, valid_q, ready_q;

  // State and registered outputs; outputs are derived from the next state so
  // that LCD_EN/rd_valid/rd_ready line up exactly with the state they describe.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      ph_q        <= '0;
      poll_cnt_q  <= '0;
      poll_mode_q <= 1'b0;
      rs_q        <= 1'b0;
      cap_q       <= 8'h00;
      rd_data_q   <= 8'h00;
      busy_q      <= 1'b1;
      ac_q        <= 7'h00;
      timeout_q   <= 1'b0;
      en_q        <= 1'b0;
      valid_q     <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      poll_cnt_q  <= poll_cnt_d;
      poll_mode_q <= poll_mode_d;
      rs_q        <= rs_d;
      cap_q       <= cap_d;
      rd_data_q   <= rd_data_d;
      busy_q      <= busy_d;
      ac_q        <= ac_d;
      timeout_q   <= timeout_d;
      en_q        <= (state_d == PULSE);
      valid_q     <= (state_d == DONE);
      ready_q     <= (state_d == IDLE);
    end
  end

  always_comb begin
    state_d     = state_q;
    ph_d        = ph_q;
    poll_cnt_d  = poll_cnt_q;
    poll_mode_d = poll_mode_q;
    rs_d        = rs_q;
    cap_d       = cap_q;
    rd_data_d   = rd_data_q;
    busy_d      = busy_q;
    ac_d        = ac_q;
    timeout_d   = timeout_q;
    unique case (state_q)
      IDLE: begin
        if (bus.poll_req) begin
          poll_mode_d = 1'b1;
          rs_d        = 1'b0;
          poll_cnt_d  = '0;
          timeout_d   = 1'b0;
          state_d     = SETUP;
          ph_d        = PH_W'(TAS_CYC - 1);
        end else if (bus.rd_req) begin
          poll_mode_d = 1'b0;
          rs_d        = bus.rd_rs;
          state_d     = SETUP;
          ph_d        = PH_W'(TAS_CYC - 1);
        end
      end
      SETUP: begin
        if (ph_q == '0) begin
          state_d = PULSE;
          ph_d    = PH_W'(TPW_CYC - 1);
        end else begin
          ph_d = ph_q - PH_W'(1);
        end
      end
      PULSE: begin
        if (ph_q == '0) begin
          cap_d   = bus.DB8;
          state_d = HOLD;
          ph_d    = PH_W'(TH_CYC - 1);
        end else begin
          ph_d = ph_q - PH_W'(1);
        end
      end
      HOLD: begin
        if (ph_q == '0) begin
          state_d = RECOV;
          ph_d    = PH_W'(TREC_CYC - 1);
        end else begin
          ph_d = ph_q - PH_W'(1);
        end
      end
      RECOV: begin
        if (ph_q == '0) begin
          // Publish the captured byte so it appears together with rd_valid.
          rd_data_d = cap_q;
          if (!rs_q) begin
            busy_d = cap_q[7];
            ac_d   = cap_q[6:0];
          end
          state_d = DONE;
          ph_d    = '0;
        end else begin
          ph_d = ph_q - PH_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        if (poll_mode_q && cap_q[7]) begin
          if (poll_cnt_q == POLL_W'(POLL_MAX - 1)) begin
            timeout_d = 1'b1;
          end else begin
            poll_cnt_d = poll_cnt_q + POLL_W'(1);
            state_d    = SETUP;
            ph_d       = PH_W'(TAS_CYC - 1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.rd_ready     = ready_q;
  assign bus.rd_valid     = valid_q;
  assign bus.rd_data      = rd_data_q;
  assign bus.busy_flag    = busy_q;
  assign bus.addr_cnt     = ac_q;
  assign bus.poll_timeout = timeout_q;
  assign bus.LCD_EN       = en_q;
  assign bus.RS           = rs_q;
  assign bus.RW           = 1'b1;

endmodule

// File: tb/tb_lcd1602_bus_reader.sv
// Directed bench for lcd1602_bus_reader: single reads, polling, timeout,
// request collisions and reset in the middle of an enable pulse.
module tb_lcd1602_bus_reader;

  logic sys_clk;
  logic sys_rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   seq_mode = 0;
  int   seq_pulses = 0;
  logic [7:0] db_fixed = 8'h00;

  lcd1602_bus_reader_if bus ();

  lcd1602_bus_reader #(.POLL_MAX(4)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus.slave)
  );

  initial sys_clk = 1'b0;
  always #10 sys_clk = ~sys_clk;

  // LCD model: poll script returns busy for the first three reads.
  always_comb bus.DB8 = seq_mode ? ((seq_pulses <= 3) ? 8'h80 : 8'h12) : db_fixed;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_access(input bit poll, input bit rd, input bit rs, input bit exp_rs,
                            input bit mid_pulse,
                            output int first_en, output int en_cyc, output int en_pulses,
                            output int valid_n, output int first_valid, output int rs_bad);
    int n;
    bit prev_en;
    bit done;
    first_en = 0; en_cyc = 0; en_pulses = 0; valid_n = 0; first_valid = 0; rs_bad = 0;
    prev_en = 0; done = 0; seq_pulses = 0; n = 0;
    @(negedge sys_clk);
    bus.poll_req = poll; bus.rd_req = rd; bus.rd_rs = rs;
    while (!done && n < 2000) begin
      @(posedge sys_clk); #1; n++;
      if (n == 1) begin
        bus.poll_req = 0; bus.rd_req = 0;
        check("ready_low_after_accept", 32'(bus.rd_ready), 0);
      end
      if (mid_pulse) bus.rd_req = (n == 20);
      if (bus.LCD_EN) begin
        en_cyc++;
        if (first_en == 0) first_en = n;
        if (!prev_en) begin en_pulses++; seq_pulses++; end
      end
      prev_en = bus.LCD_EN;
      if (bus.rd_valid) begin
        valid_n++;
        if (first_valid == 0) first_valid = n;
      end
      if (!bus.rd_ready && (bus.RS !== exp_rs || bus.RW !== 1'b1)) rs_bad++;
      if (bus.rd_ready && n > 1) done = 1;
    end
    bus.rd_req = 0;
    check("finished_in_budget", 32'(done), 1);
  endtask

  int fe, ec, ep, vn, fv, rb;

  initial begin
    int extra_en;
    bus.rd_req = 0; bus.rd_rs = 0; bus.poll_req = 0;
    sys_rst = 1;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 0;
    check("rst_ready",   32'(bus.rd_ready), 1);
    check("rst_en",      32'(bus.LCD_EN), 0);
    check("rst_rs",      32'(bus.RS), 0);
    check("rst_rw",      32'(bus.RW), 1);
    check("rst_valid",   32'(bus.rd_valid), 0);
    check("rst_data",    32'(bus.rd_data), 8'h00);
    check("rst_busy",    32'(bus.busy_flag), 1);
    check("rst_ac",      32'(bus.addr_cnt), 7'h00);
    check("rst_timeout", 32'(bus.poll_timeout), 0);

    // Status read of 0x45
    db_fixed = 8'h45;
    run_access(0, 1, 0, 0, 0, fe, ec, ep, vn, fv, rb);
    check("st_first_en",    32'(fe), 4);
    check("st_en_cycles",   32'(ec), 25);
    check("st_en_pulses",   32'(ep), 1);
    check("st_valid_cnt",   32'(vn), 1);
    check("st_latency",     32'(fv), 56);
    check("st_rs_rw",       32'(rb), 0);
    check("st_data",        32'(bus.rd_data), 8'h45);
    check("st_busy",        32'(bus.busy_flag), 0);
    check("st_ac",          32'(bus.addr_cnt), 7'h45);

    // Poll timeout with BF stuck high
    db_fixed = 8'hFF;
    run_access(1, 0, 0, 0, 0, fe, ec, ep, vn, fv, rb);
    check("to_en_pulses",   32'(ep), 4);
    check("to_en_cycles",   32'(ec), 100);
    check("to_valid_cnt",   32'(vn), 4);
    check("to_timeout",     32'(bus.poll_timeout), 1);
    check("to_ready",       32'(bus.rd_ready), 1);
    check("to_busy",        32'(bus.busy_flag), 1);
    check("to_ac",          32'(bus.addr_cnt), 7'h7F);

    // Data read leaves BF/AC and the sticky timeout alone
    db_fixed = 8'hA5;
    run_access(0, 1, 1, 1, 0, fe, ec, ep, vn, fv, rb);
    check("dr_data",        32'(bus.rd_data), 8'hA5);
    check("dr_rs_rw",       32'(rb), 0);
    check("dr_latency",     32'(fv), 56);
    check("dr_busy",        32'(bus.busy_flag), 1);
    check("dr_ac",          32'(bus.addr_cnt), 7'h7F);
    check("dr_timeout",     32'(bus.poll_timeout), 1);

    // Poll: busy three times then 0x12
    seq_mode = 1;
    run_access(1, 0, 0, 0, 0, fe, ec, ep, vn, fv, rb);
    seq_mode = 0;
    check("pl_en_pulses",   32'(ep), 4);
    check("pl_valid_cnt",   32'(vn), 4);
    check("pl_data",        32'(bus.rd_data), 8'h12);
    check("pl_busy",        32'(bus.busy_flag), 0);
    check("pl_ac",          32'(bus.addr_cnt), 7'h12);
    check("pl_timeout",     32'(bus.poll_timeout), 0);

    // rd_req and poll_req together: poll wins, RS=0; mid-access rd_req ignored
    db_fixed = 8'h07;
    run_access(1, 1, 1, 0, 1, fe, ec, ep, vn, fv, rb);
    check("co_rs_rw",       32'(rb), 0);
    check("co_en_pulses",   32'(ep), 1);
    check("co_valid_cnt",   32'(vn), 1);
    check("co_busy",        32'(bus.busy_flag), 0);
    check("co_ac",          32'(bus.addr_cnt), 7'h07);
    extra_en = 0;
    repeat (80) begin
      @(posedge sys_clk); #1;
      if (bus.LCD_EN || !bus.rd_ready) extra_en++;
    end
    check("co_no_extra",    32'(extra_en), 0);

    // Reset in the 10th enable-high cycle
    begin
      int hi;
      int n;
      hi = 0; n = 0;
      db_fixed = 8'h33;
      @(negedge sys_clk);
      bus.rd_req = 1; bus.rd_rs = 1;
      while (hi < 10 && n < 200) begin
        @(posedge sys_clk); #1; n++;
        bus.rd_req = 0;
        if (bus.LCD_EN) hi++;
      end
      check("rp_reached_pulse", 32'(hi), 10);
      sys_rst = 1;
      @(posedge sys_clk); #1;
      check("rp_en",      32'(bus.LCD_EN), 0);
      check("rp_valid",   32'(bus.rd_valid), 0);
      check("rp_rs",      32'(bus.RS), 0);
      check("rp_data",    32'(bus.rd_data), 8'h00);
      check("rp_busy",    32'(bus.busy_flag), 1);
      check("rp_ac",      32'(bus.addr_cnt), 7'h00);
      check("rp_timeout", 32'(bus.poll_timeout), 0);
      @(posedge sys_clk); #1;
      sys_rst = 0;
      @(posedge sys_clk); #1;
      check("rp_ready_after", 32'(bus.rd_ready), 1);
      extra_en = 0;
      repeat (80) begin
        @(posedge sys_clk); #1;
        if (bus.rd_valid || bus.LCD_EN) extra_en++;
      end
      check("rp_no_valid",    32'(extra_en), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
